// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, in-order tag queue and decode FIFO.
// Optional FETCH_PERF_EN adds saturating fetched/discarded response counters.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [31:0]     i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_insn_vld,
   output logic [31:0]     o_insn,
   output logic [XLEN-1:0] o_insn_pc,
   input  logic            i_insn_rdy,
   output logic [XLEN-1:0] o_pc_debug
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     o_perf_fetched,
   output logic [31:0]     o_perf_discarded
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] ALIGN = ~(XLEN'(3));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [PW-1:0]   tag_wp_q;
   logic [PW-1:0]   tag_rp_q;
   logic [XLEN-1:0] pc_dbg_q;

   logic [31:0]     insn_mem_q [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem_q   [FIFO_DEPTH];
   logic [XLEN-1:0] tag_mem_q  [FIFO_DEPTH];

   logic [CW:0] credit;
   logic        issue;
   logic        rsp;
   logic        push;
   logic        pop;

   // Credit uses registered occupancy only; a same-cycle pop is not counted.
   assign credit     = {1'b0, cnt_q} + {1'b0, outst_q};
   assign o_imem_req = (state_q == S_FETCH) && (credit < DEPTH_W);
   assign issue      = o_imem_req & i_imem_gnt;
   assign rsp        = i_imem_rvalid & (outst_q != '0);
   assign push       = rsp & (state_q == S_FETCH) & ~i_redirect;
   assign o_insn_vld = (cnt_q != '0);
   assign pop        = o_insn_vld & i_insn_rdy & ~i_redirect;

   assign o_imem_addr = fetch_pc_q & ALIGN;
   assign o_insn      = o_insn_vld ? insn_mem_q[rptr_q] : 32'd0;
   assign o_insn_pc   = o_insn_vld ? pc_mem_q[rptr_q] : '0;
   assign o_pc_debug  = pc_dbg_q;

   assign outst_d = outst_q + CW'(issue) - CW'(rsp);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      if (i_redirect) begin
         fetch_pc_d = i_redirect_pc & ALIGN;
         discard_d  = outst_d;
         state_d    = (outst_d != '0) ? S_DRAIN : S_FETCH;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            S_DRAIN: begin
               if (rsp) begin
                  discard_d = discard_q - CW'(1);
                  if (discard_q == CW'(1)) state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (i_redirect) begin
         cnt_d  = '0;
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(push) - CW'(pop);
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         tag_wp_q   <= '0;
         tag_rp_q   <= '0;
         pc_dbg_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         if (issue) tag_wp_q <= tag_wp_q + PW'(1);
         if (rsp)   tag_rp_q <= tag_rp_q + PW'(1);
         if (pop)   pc_dbg_q <= o_insn_pc;
      end
   end

   // Tags are consumed by every response, kept or dropped, to stay aligned.
   always_ff @(posedge i_clk) begin
      if (issue) tag_mem_q[tag_wp_q] <= fetch_pc_q & ALIGN;
      if (push) begin
         insn_mem_q[wptr_q] <= i_imem_rdata;
         pc_mem_q[wptr_q]   <= tag_mem_q[tag_rp_q];
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_f_q;
   logic [31:0] perf_d_q;
   logic        drop;

   assign drop = rsp & ~push;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         perf_f_q <= '0;
         perf_d_q <= '0;
      end else begin
         if (push && perf_f_q != 32'hFFFF_FFFF) perf_f_q <= perf_f_q + 32'd1;
         if (drop && perf_d_q != 32'hFFFF_FFFF) perf_d_q <= perf_d_q + 32'd1;
      end
   end

   assign o_perf_fetched   = perf_f_q;
   assign o_perf_discarded = perf_d_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against
// a reference model of the expected fetch and decode PC streams.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        insn_vld;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        insn_rdy;
   logic [31:0] pc_debug;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_discarded;
`endif

   fetch_unit #(
      .XLEN(32),
      .RESET_PC(32'h0000_0000),
      .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
      .o_imem_req(imem_req),
      .o_imem_addr(imem_addr),
      .i_imem_gnt(imem_gnt),
      .i_imem_rvalid(imem_rvalid),
      .i_imem_rdata(imem_rdata),
      .i_redirect(redirect),
      .i_redirect_pc(redirect_pc),
      .o_insn_vld(insn_vld),
      .o_insn(insn),
      .o_insn_pc(insn_pc),
      .i_insn_rdy(insn_rdy),
      .o_pc_debug(pc_debug)
`ifdef FETCH_PERF_EN
      ,
      .o_perf_fetched(perf_fetched),
      .o_perf_discarded(perf_discarded)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] popped[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          grants = 0;
   int          pops = 0;
   logic [31:0] m_fpc;
   logic [31:0] m_dec;
   logic [31:0] m_dbg;
   logic        s_req, s_vld, s_rv, s_pop;
   logic [31:0] s_addr, s_ipc, s_insn, s_dbg;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_fpc = 32'h0;
      m_dec = 32'h0;
      m_dbg = 32'h0;
   endtask

   // One cycle: sample at negedge, drive inputs, advance the model to the posedge.
   task automatic step(input bit gnt, input bit rdy, input bit redir,
                       input logic [31:0] rpc, input int lat, input bit spur);
      logic rv;
      logic issue;
      @(negedge clk);
      cyc++;
      s_req  = imem_req;
      s_addr = imem_addr;
      s_vld  = insn_vld;
      s_ipc  = insn_pc;
      s_insn = insn;
      s_dbg  = pc_debug;
      chk("pc_debug", s_dbg, m_dbg);
      if (s_req) chk("imem_addr", s_addr, m_fpc);
      rv = 1'b0;
      imem_rdata = 32'h0;
      if (pend.size() != 0) begin
         if (pend[0].due <= cyc) begin
            rv = 1'b1;
            imem_rdata = memf(pend[0].addr);
         end
      end else if (spur) begin
         rv = 1'b1;
         imem_rdata = $urandom;
      end
      imem_gnt    = gnt;
      insn_rdy    = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      imem_rvalid = rv;
      issue = s_req & gnt;
      s_pop = s_vld & rdy & ~redir;
      s_rv  = rv;
      if (s_pop) begin
         chk("insn_pc", s_ipc, m_dec);
         chk("insn", s_insn, memf(s_ipc));
         popped.push_back(s_ipc);
         pops++;
      end
      if (rv && pend.size() != 0) void'(pend.pop_front());
      if (issue) begin
         pend.push_back('{addr: m_fpc, due: cyc + lat});
         grants++;
      end
      if (redir) begin
         m_fpc = {rpc[31:2], 2'b00};
         m_dec = {rpc[31:2], 2'b00};
      end else begin
         if (issue) m_fpc = m_fpc + 32'd4;
         if (s_pop) begin
            m_dbg = s_ipc;
            m_dec = m_dec + 32'd4;
         end
      end
   endtask

   task automatic settle();
      int n = 0;
      while ((pend.size() != 0 || insn_vld) && n < 100) begin
         step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
         n++;
      end
      chk("settle_timeout", 32'(n < 100), 32'd1);
   endtask

   task automatic first_pop(input logic [31:0] exp, input string tag);
      int n = 0;
      s_pop = 1'b0;
      while (!s_pop && n < 100) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 100), 32'd1);
      chk(tag, s_ipc, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_vld"}, 32'(insn_vld), 32'd0);
      chk({tag, "_insn"}, insn, 32'h0);
      chk({tag, "_ipc"}, insn_pc, 32'h0);
      chk({tag, "_dbg"}, pc_debug, 32'h0);
`ifdef FETCH_PERF_EN
      chk({tag, "_pf"}, perf_fetched, 32'h0);
      chk({tag, "_pd"}, perf_discarded, 32'h0);
`endif
   endtask

   initial begin
      int n;
      int drops;
      logic [31:0] addrs[$];
      rst_n = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      insn_rdy = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;

      // Streaming with a 1-cycle memory
      step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      chk("first_req", 32'(s_req), 32'd1);
      chk("first_addr", s_addr, 32'h0);
      repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      chk("stream_pops", 32'(popped.size() >= 3), 32'd1);
      if (popped.size() >= 3) begin
         chk("seq0", popped[0], 32'h0);
         chk("seq1", popped[1], 32'h4);
         chk("seq2", popped[2], 32'h8);
      end

      // Backpressure: credit limit of FIFO_DEPTH
      step(1'b0, 1'b1, 1'b1, 32'h40, 1, 1'b0);
      settle();
      grants = 0;
      repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      chk("full_grants", 32'(grants), 32'd4);
      chk("full_req", 32'(s_req), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      grants = 0;
      repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      chk("refill_grants", 32'(grants), 32'd1);

      // Redirect with 3 outstanding
      step(1'b0, 1'b1, 1'b1, 32'h200, 1, 1'b0);
      settle();
      grants = 0;
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 5, 1'b0);
      chk("out3_grants", 32'(grants), 32'd3);
      step(1'b0, 1'b1, 1'b1, 32'h103, 1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      chk("flush_vld", 32'(s_vld), 32'd0);
      n = 0;
      drops = 0;
      while (!s_req && n < 50) begin
         if (s_rv) drops++;
         step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
         n++;
      end
      chk("drain_drops", 32'(drops), 32'd3);
      chk("redir_addr", s_addr, 32'h100);
      first_pop(32'h100, "redir_first");

      // Redirect coinciding with response and grant
      step(1'b0, 1'b1, 1'b1, 32'h300, 1, 1'b0);
      settle();
      repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 2, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h400, 2, 1'b0);
      chk("coin_req", 32'(s_req), 32'd1);
      chk("coin_rv", 32'(s_rv), 32'd1);
      n = 0;
      drops = 0;
      s_req = 1'b0;
      while (!s_req && n < 50) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
         if (s_rv && !s_req) drops++;
         n++;
      end
      chk("coin_drops", 32'(drops), 32'd2);
      first_pop(32'h400, "coin_first");

      // PC wrap at the top of the address space
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1, 1'b0);
      settle();
      n = 0;
      while (addrs.size() < 3 && n < 20) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
         if (s_req) addrs.push_back(s_addr);
         n++;
      end
      chk("wrap_n", 32'(addrs.size()), 32'd3);
      if (addrs.size() == 3) begin
         chk("wrap_a1", addrs[1], 32'hFFFF_FFFC);
         chk("wrap_a2", addrs[2], 32'h0000_0000);
      end

      // Asynchronous reset with 2 outstanding
      step(1'b0, 1'b1, 1'b1, 32'h500, 1, 1'b0);
      settle();
      repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 20, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      redirect = 1'b0;
      insn_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      chk("rst_req", 32'(s_req), 32'd1);
      chk("rst_addr", s_addr, 32'h0);
      first_pop(32'h0, "rst_first");

      // Random traffic
      pops = 0;
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 4) != 0, ($urandom % 3) != 0,
              ($urandom % 16) == 0, $urandom,
              int'($urandom_range(1, 4)), ($urandom % 8) == 0);
      end
      chk("rand_progress", 32'(pops > 100), 32'd1);
      step(1'b0, 1'b1, 1'b1, 32'h0, 1, 1'b0);
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
